// File: rtl/matmul3x3_pkg.sv
// Shared constants, state encoding and index helper for the 3x3 sequential matrix multiplier.
// The optional saturating write-back is selected with the MATMUL3X3_SAT_EN macro (see matmul3x3_mac).
package matmul3x3_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int ACC_W  = 34;
  localparam int RES_W  = 32;
  localparam int N_ELEM = 9;

  localparam logic [5:0] W_CTRL   = 6'd0;
  localparam logic [5:0] W_STATUS = 6'd1;
  localparam logic [5:0] W_A_BASE = 6'd4;
  localparam logic [5:0] W_A_LAST = 6'd12;
  localparam logic [5:0] W_B_BASE = 6'd16;
  localparam logic [5:0] W_B_LAST = 6'd24;
  localparam logic [5:0] W_C_BASE = 6'd28;
  localparam logic [5:0] W_C_LAST = 6'd36;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Row-major flat index of element [r][c].
  function automatic logic [3:0] elem_idx(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} * 4'd3) + {2'b00, c};
  endfunction

endpackage

// File: rtl/matmul3x3_mac.sv
// Single MAC lane: signed 16x16 product folded into a 34-bit accumulator each enabled cycle.
// With MATMUL3X3_SAT_EN defined the result is clipped to 32-bit signed range; otherwise it wraps.
module matmul3x3_mac
  import matmul3x3_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  input  logic                   first_i,
  input  logic signed [OP_W-1:0] a_i,
  input  logic signed [OP_W-1:0] b_i,
  output logic [RES_W-1:0]       res_o,
  output logic                   clip_o
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  sum;

  assign prod     = a_i * b_i;
  assign acc_base = first_i ? '0 : acc_q;
  assign sum      = acc_base + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  // The sum is also the write-back value, so C can be stored on the same cycle as the last product.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = sum;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef MATMUL3X3_SAT_EN
  // Fits in 32 bits only when the top three bits agree.
  always_comb begin
    res_o  = sum[RES_W-1:0];
    clip_o = 1'b0;
    if (!((sum[ACC_W-1:RES_W-1] == 3'b000) || (sum[ACC_W-1:RES_W-1] == 3'b111))) begin
      clip_o = 1'b1;
      res_o  = sum[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  assign res_o  = sum[RES_W-1:0];
  assign clip_o = 1'b0;
`endif

endmodule

// File: rtl/matmul3x3_seq.sv
// Register-mapped 3x3 signed matrix multiplier: C = A * B, one MAC per cycle over 27 cycles.
// Optional saturation of C is enabled by defining MATMUL3X3_SAT_EN.
module matmul3x3_seq
  import matmul3x3_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 20,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [ADDR_W-1:0] sys_addr_i,
  input  logic [31:0]       sys_wdata_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  output logic [31:0]       sys_rdata_o,
  output logic              sys_ack_o,
  output logic              irq_o
);

  logic [ADDR_W-1:0] offset;
  logic [5:0]        word;
  logic              in_range;
  logic              wr, ctrl_wr, a_wr, b_wr;
  logic [5:0]        a_off, b_off, c_off;

  logic [OP_W-1:0]   a_q [0:N_ELEM-1];
  logic [OP_W-1:0]   b_q [0:N_ELEM-1];
  logic [RES_W-1:0]  c_q [0:N_ELEM-1];

  state_t            state_q, state_d;
  logic [1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic              start_q, start_d;
  logic              done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic              irq_q, irq_d;
  logic              ack_q;
  logic [31:0]       rdata_q, rd_val;
  logic              busy_int, busy_status;
  logic              mac_en, c_we;
  logic [RES_W-1:0]  mac_res;
  logic              mac_clip;
  logic [OP_W-1:0]   mac_a, mac_b;
  logic              unused_bits;

  assign offset   = sys_addr_i - BASE_ADDR;
  assign in_range = (offset[ADDR_W-1:8] == '0);
  assign word     = offset[7:2];
  assign a_off    = word - W_A_BASE;
  assign b_off    = word - W_B_BASE;
  assign c_off    = word - W_C_BASE;

  assign wr      = sys_wen_i & in_range;
  assign ctrl_wr = wr && (word == W_CTRL);
  assign a_wr    = wr && (word >= W_A_BASE) && (word <= W_A_LAST);
  assign b_wr    = wr && (word >= W_B_BASE) && (word <= W_B_LAST);

  // A start accepted but not yet in RUN must also block further starts and operand writes.
  assign busy_status = (state_q != S_IDLE);
  assign busy_int    = busy_status | start_q;

  assign unused_bits = ^{offset[1:0], a_off[5:4], b_off[5:4], c_off[5:4], sys_wdata_i[31:16]};

  assign mac_a = a_q[elem_idx(i_q, k_q)];
  assign mac_b = b_q[elem_idx(k_q, j_q)];

  matmul3x3_mac u_mac (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .en_i    (mac_en),
    .first_i (k_q == 2'd0),
    .a_i     (mac_a),
    .b_i     (mac_b),
    .res_o   (mac_res),
    .clip_o  (mac_clip)
  );

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    mac_en  = 1'b0;
    c_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_RUN;
          i_d     = 2'd0;
          j_d     = 2'd0;
          k_d     = 2'd0;
        end
      end
      S_RUN: begin
        mac_en = 1'b1;
        if (k_q == 2'd2) begin
          c_we = 1'b1;
          k_d  = 2'd0;
          if (j_q == 2'd2) begin
            j_d = 2'd0;
            if (i_q == 2'd2) begin
              i_d     = 2'd0;
              state_d = S_DONE;
            end else begin
              i_d = i_q + 2'd1;
            end
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Clear is applied before start so a combined write clears then launches.
  always_comb begin
    done_d  = done_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    start_d = 1'b0;
    irq_d   = 1'b0;
    if (ctrl_wr && sys_wdata_i[1]) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      ovf_d  = 1'b0;
    end
    if (ctrl_wr && sys_wdata_i[0]) begin
      if (busy_int) begin
        err_d = 1'b1;
      end else begin
        start_d = 1'b1;
      end
    end
    if ((a_wr || b_wr) && busy_int) begin
      err_d = 1'b1;
    end
    if (start_q) begin
      done_d = 1'b0;
    end
    if (c_we && mac_clip) begin
      ovf_d = 1'b1;
    end
    if ((state_q == S_RUN) && (state_d == S_DONE)) begin
      done_d = 1'b1;
      irq_d  = 1'b1;
    end
  end

  always_comb begin
    rd_val = '0;
    if (word == W_STATUS) begin
      rd_val = {28'd0, ovf_q, err_q, done_q, busy_status};
    end else if ((word >= W_A_BASE) && (word <= W_A_LAST)) begin
      rd_val = {{16{a_q[a_off[3:0]][OP_W-1]}}, a_q[a_off[3:0]]};
    end else if ((word >= W_B_BASE) && (word <= W_B_LAST)) begin
      rd_val = {{16{b_q[b_off[3:0]][OP_W-1]}}, b_q[b_off[3:0]]};
    end else if ((word >= W_C_BASE) && (word <= W_C_LAST)) begin
      rd_val = c_q[c_off[3:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
      ack_q   <= (sys_wen_i | sys_ren_i) & in_range;
      rdata_q <= (sys_ren_i & in_range) ? rd_val : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < N_ELEM; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      if (a_wr && !busy_int) begin
        a_q[a_off[3:0]] <= sys_wdata_i[OP_W-1:0];
      end
      if (b_wr && !busy_int) begin
        b_q[b_off[3:0]] <= sys_wdata_i[OP_W-1:0];
      end
      if (c_we) begin
        c_q[elem_idx(i_q, j_q)] <= mac_res;
      end
    end
  end

  assign sys_rdata_o = rdata_q;
  assign sys_ack_o   = ack_q;
  assign irq_o       = irq_q;

endmodule
